spi_ram_ctrl: RTL and testbench

//  Command controller between the SPI slave and a synchronous single-port RAM.

---
 rtl/spi_ram_ctrl_if.sv | 42 ++++
 rtl/spi_ram_ctrl.sv | 150 +++++++++++++++
 tb/tb_spi_ram_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_ctrl_if.sv
// spi_ram_ctrl_if
//   Bundles the SPI-slave side, RAM side and status signals of spi_ram_ctrl.
//   slave  modport: seen by the controller.
//   master modport: seen by whatever surrounds the controller (SPI slave + RAM).
//   Signals:
//     rx_data[9:0], rx_valid     word from SPI slave ([9:8]=cmd, [7:0]=payload)
//     tx_data[7:0], tx_valid     read data back to SPI slave
//     ram_en, ram_we             RAM strobe and direction
//     ram_addr, ram_wdata        RAM address / write data
//     ram_rdata                  RAM read data
//     busy                       controller not in IDLE
//     clr_err                    clear of sticky error flags
//     err_ovf, err_seq           sticky error flags
interface spi_ram_ctrl_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [9:0]            rx_data;
  logic                  rx_valid;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_wdata;
  logic [7:0]            ram_rdata;
  logic                  busy;
  logic                  clr_err;
  logic                  err_ovf;
  logic                  err_seq;

  modport slave (
    input  rx_data, rx_valid, ram_rdata, clr_err,
    output tx_data, tx_valid, ram_en, ram_we, ram_addr, ram_wdata,
           busy, err_ovf, err_seq
  );

  modport master (
    output rx_data, rx_valid, ram_rdata, clr_err,
    input  tx_data, tx_valid, ram_en, ram_we, ram_addr, ram_wdata,
           busy, err_ovf, err_seq
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl
//   Command controller between an SPI slave and a synchronous single-port RAM.
//   Each 10-bit word from the slave is decoded into a pointer load, a RAM
//   write or a RAM read; read data is returned on tx_data/tx_valid.
//   Ports:
//     clk    clock
//     rst_n  asynchronous reset, active-low
//     bus    spi_ram_ctrl_if.slave (rx/tx handshake, RAM port, status flags)
//   Commands (rx_data[9:8]):
//     00 load write pointer   01 write payload at write pointer
//     10 load read pointer    11 read at read pointer
module spi_ram_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int RAM_LATENCY = 1,
  parameter int AUTO_INC    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_ISSUE = 2'd2,
    RD_WAIT  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_STEP = (AUTO_INC != 0) ? ADDR_WIDTH'(1) : '0;
  localparam logic [1:0]            WAIT_LAST = 2'(RAM_LATENCY - 1);

  state_t                state, state_nx;
  logic                  rx_valid_q;
  logic                  new_word;
  logic                  accept;
  logic [1:0]            cmd;
  logic [7:0]            payload;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_seen;
  logic [1:0]            wait_cnt;
  logic                  busy_q;

  assign cmd      = bus.rx_data[9:8];
  assign payload  = bus.rx_data[7:0];
  // rx_valid is a level; only its rising edge marks a new word.
  assign new_word = bus.rx_valid & ~rx_valid_q;
  assign accept   = new_word && (state == IDLE);
  assign bus.busy = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd == 2'b01)      state_nx = WRITE;
          else if (cmd == 2'b11) state_nx = RD_ISSUE;
        end
      end
      WRITE:    state_nx = IDLE;
      RD_ISSUE: state_nx = RD_WAIT;
      RD_WAIT:  if (wait_cnt == WAIT_LAST) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // RAM strobes are registered on the accept edge so the access occupies
  // exactly the WRITE / RD_ISSUE cycle; address and data hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q    <= 1'b1;  // a word already present at release is ignored
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rd_seen       <= 1'b0;
      wait_cnt      <= '0;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.tx_data   <= '0;
      bus.tx_valid  <= 1'b0;
    end else begin
      rx_valid_q <= bus.rx_valid;
      bus.ram_en <= 1'b0;

      if (accept) begin
        bus.tx_valid <= 1'b0;
        case (cmd)
          2'b00: wr_ptr <= payload[ADDR_WIDTH-1:0];
          2'b01: begin
            bus.ram_en    <= 1'b1;
            bus.ram_we    <= 1'b1;
            bus.ram_addr  <= wr_ptr;
            bus.ram_wdata <= payload;
          end
          2'b10: begin
            rd_ptr  <= payload[ADDR_WIDTH-1:0];
            rd_seen <= 1'b1;
          end
          default: begin
            bus.ram_en   <= 1'b1;
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= rd_ptr;
          end
        endcase
      end

      if (state == WRITE) wr_ptr <= wr_ptr + PTR_STEP;

      if (state == RD_ISSUE) begin
        rd_ptr   <= rd_ptr + PTR_STEP;
        wait_cnt <= '0;
      end

      if (state == RD_WAIT) begin
        wait_cnt <= wait_cnt + 2'd1;
        // Last wait cycle is exactly when the RAM presents the read data.
        if (wait_cnt == WAIT_LAST) begin
          bus.tx_data  <= bus.ram_rdata;
          bus.tx_valid <= 1'b1;
        end
      end
    end
  end

  // Sticky error flags; a clear wins over a set in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err_ovf <= 1'b0;
      bus.err_seq <= 1'b0;
    end else if (bus.clr_err) begin
      bus.err_ovf <= 1'b0;
      bus.err_seq <= 1'b0;
    end else begin
      if (new_word && (state != IDLE))              bus.err_ovf <= 1'b1;
      if (accept && (cmd == 2'b11) && !rd_seen)     bus.err_seq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
module tb_spi_ram_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_ram_ctrl_if #(.ADDR_WIDTH(8)) bus1 ();
  spi_ram_ctrl_if #(.ADDR_WIDTH(8)) bus4 ();

  spi_ram_ctrl #(.ADDR_WIDTH(8), .RAM_LATENCY(1), .AUTO_INC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  spi_ram_ctrl #(.ADDR_WIDTH(8), .RAM_LATENCY(4), .AUTO_INC(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  // RAM models: read data appears RAM_LATENCY cycles after the ram_en cycle,
  // filler value otherwise so that mistimed sampling shows up.
  logic [7:0] mem1 [256];
  logic [7:0] rd1;
  always @(posedge clk) begin
    if (bus1.ram_en && bus1.ram_we) mem1[bus1.ram_addr] <= bus1.ram_wdata;
    rd1 <= (bus1.ram_en && !bus1.ram_we) ? mem1[bus1.ram_addr] : 8'hEE;
  end
  assign bus1.ram_rdata = rd1;

  logic [7:0] mem4 [256];
  logic [7:0] pipe4 [4];
  always @(posedge clk) begin
    if (bus4.ram_en && bus4.ram_we) mem4[bus4.ram_addr] <= bus4.ram_wdata;
    pipe4[0] <= (bus4.ram_en && !bus4.ram_we) ? mem4[bus4.ram_addr] : 8'hEE;
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
    pipe4[3] <= pipe4[2];
  end
  assign bus4.ram_rdata = pipe4[3];

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  acc_t       acc_q [$];
  logic [7:0] tx_q  [$];
  logic [7:0] model_mem [256];
  logic [7:0] wr_m, rd_m;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard for u_dut: every RAM access and every tx_valid rise is popped
  // against what the stimulus pushed.
  task automatic monitor1();
    logic tx_prev = 1'b0;
    acc_t e;
    logic [7:0] t;
    forever begin
      @(negedge clk);
      if (bus1.ram_en === 1'b1) begin
        n_checks++;
        if (acc_q.size() == 0) begin
          n_fail++;
          $display("FAIL ram_access: got unexpected we=%b addr=%h, required no access", bus1.ram_we, bus1.ram_addr);
        end else begin
          e = acc_q.pop_front();
          if (bus1.ram_we !== e.we || bus1.ram_addr !== e.addr || (e.we && bus1.ram_wdata !== e.wdata)) begin
            n_fail++;
            $display("FAIL ram_access: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                     bus1.ram_we, bus1.ram_addr, bus1.ram_wdata, e.we, e.addr, e.wdata);
          end
        end
      end
      if (bus1.tx_valid === 1'b1 && !tx_prev) begin
        n_checks++;
        if (tx_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_data: got unexpected tx %h, required none", bus1.tx_data);
        end else begin
          t = tx_q.pop_front();
          if (bus1.tx_data !== t) begin
            n_fail++;
            $display("FAIL tx_data: got %h, required %h", bus1.tx_data, t);
          end
        end
      end
      tx_prev = bus1.tx_valid;
    end
  endtask

  // Stimulus helpers for u_dut. send1 returns 1 time unit after the accept edge.
  task automatic send1(input logic [9:0] w);
    @(posedge clk); #1;
    bus1.rx_data  = w;
    bus1.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus1.rx_valid = 1'b0;
  endtask

  task automatic wait_idle1();
    int n = 0;
    while (bus1.busy !== 1'b0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle1: busy=%b after %0d cycles, required 0", bus1.busy, n);
    end
  endtask

  task automatic set_wr1(input logic [7:0] p);
    send1({2'b00, p});
    wr_m = p;
  endtask

  task automatic set_rd1(input logic [7:0] p);
    send1({2'b10, p});
    rd_m = p;
  endtask

  task automatic do_write1(input logic [7:0] d);
    acc_q.push_back('{we: 1'b1, addr: wr_m, wdata: d});
    model_mem[wr_m] = d;
    wr_m = wr_m + 8'd1;
    send1({2'b01, d});
    wait_idle1();
  endtask

  task automatic do_read1();
    acc_q.push_back('{we: 1'b0, addr: rd_m, wdata: 8'h00});
    tx_q.push_back(model_mem[rd_m]);
    rd_m = rd_m + 8'd1;
    send1(10'h300);
    wait_idle1();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wr_m = 8'h00;
    rd_m = 8'h00;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if ({bus1.ram_en, bus1.ram_we, bus1.tx_valid, bus1.busy, bus1.err_ovf, bus1.err_seq} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl1: got en/we/txv/busy/ovf/seq=%b, required 000000",
               {bus1.ram_en, bus1.ram_we, bus1.tx_valid, bus1.busy, bus1.err_ovf, bus1.err_seq});
    end
    n_checks++;
    if ({bus1.tx_data, bus1.ram_addr, bus1.ram_wdata} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_data1: got tx/addr/wdata=%h, required 000000", {bus1.tx_data, bus1.ram_addr, bus1.ram_wdata});
    end
    n_checks++;
    if ({bus4.ram_en, bus4.tx_valid, bus4.busy, bus4.err_ovf, bus4.err_seq} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl4: got en/txv/busy/ovf/seq=%b, required 00000",
               {bus4.ram_en, bus4.tx_valid, bus4.busy, bus4.err_ovf, bus4.err_seq});
    end
  endtask

  task automatic test_write();
    set_wr1(8'hA5);
    acc_q.push_back('{we: 1'b1, addr: 8'hA5, wdata: 8'h3C});
    model_mem[8'hA5] = 8'h3C;
    wr_m = 8'hA6;
    send1(10'h13C);
    n_checks++;
    if (bus1.ram_en !== 1'b1 || bus1.ram_we !== 1'b1 || bus1.ram_addr !== 8'hA5 || bus1.ram_wdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL t1_write: got en=%b we=%b addr=%h wdata=%h, required 1 1 a5 3c",
               bus1.ram_en, bus1.ram_we, bus1.ram_addr, bus1.ram_wdata);
    end
    n_checks++;
    if (bus1.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_busy: got %b, required 1", bus1.busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus1.ram_en !== 1'b0 || bus1.busy !== 1'b0 || bus1.ram_addr !== 8'hA5) begin
      n_fail++;
      $display("FAIL t1_after: got en=%b busy=%b addr=%h, required 0 0 a5", bus1.ram_en, bus1.busy, bus1.ram_addr);
    end
  endtask

  task automatic test_read();
    set_rd1(8'hA5);
    acc_q.push_back('{we: 1'b0, addr: 8'hA5, wdata: 8'h00});
    tx_q.push_back(8'h3C);
    rd_m = 8'hA6;
    send1(10'h300);
    n_checks++;
    if (bus1.ram_en !== 1'b1 || bus1.ram_we !== 1'b0 || bus1.ram_addr !== 8'hA5) begin
      n_fail++;
      $display("FAIL t2_issue: got en=%b we=%b addr=%h, required 1 0 a5", bus1.ram_en, bus1.ram_we, bus1.ram_addr);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus1.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_early: got tx_valid=%b at A+2, required 0", bus1.tx_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus1.tx_valid !== 1'b1 || bus1.tx_data !== 8'h3C || bus1.busy !== 1'b0 || bus1.err_seq !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_data: got txv=%b tx=%h busy=%b seq=%b at A+3, required 1 3c 0 0",
               bus1.tx_valid, bus1.tx_data, bus1.busy, bus1.err_seq);
    end
  endtask

  task automatic test_wrap();
    set_wr1(8'hFF);
    do_write1(8'h11);
    do_write1(8'h22);
    do_write1(8'h33);
    set_rd1(8'hFF);
    do_read1();
    do_read1();
    n_checks++;
    if (bus1.tx_valid !== 1'b1 || bus1.tx_data !== 8'h22) begin
      n_fail++;
      $display("FAIL t3_wrap: got txv=%b tx=%h, required 1 22", bus1.tx_valid, bus1.tx_data);
    end
  endtask

  task automatic test_overflow();
    int en_cnt = 0;
    logic [7:0] en_addr = 8'h00;
    logic [7:0] en_wd = 8'h00;
    @(posedge clk); #1;
    bus4.rx_data  = 10'h15A;
    bus4.rx_valid = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus4.ram_en === 1'b1) begin
        en_cnt++;
        en_addr = bus4.ram_addr;
        en_wd   = bus4.ram_wdata;
      end
    end
    bus4.rx_valid = 1'b0;
    n_checks++;
    if (en_cnt != 1 || en_addr !== 8'h00 || en_wd !== 8'h5A) begin
      n_fail++;
      $display("FAIL t4_held: got %0d accesses last addr=%h wdata=%h, required 1 00 5a", en_cnt, en_addr, en_wd);
    end
    // read at 00 with a second rising edge while busy
    @(posedge clk); #1;
    bus4.rx_data  = 10'h300;
    bus4.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus4.rx_valid = 1'b0;
    n_checks++;
    if (bus4.ram_en !== 1'b1 || bus4.ram_we !== 1'b0 || bus4.ram_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL t4_issue: got en=%b we=%b addr=%h, required 1 0 00", bus4.ram_en, bus4.ram_we, bus4.ram_addr);
    end
    @(posedge clk); #1;
    bus4.rx_data  = 10'h199;
    bus4.rx_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus4.err_ovf !== 1'b1 || bus4.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_ovf: got err_ovf=%b busy=%b, required 1 1", bus4.err_ovf, bus4.busy);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (bus4.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_early: got tx_valid=%b at A+5, required 0", bus4.tx_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus4.tx_valid !== 1'b1 || bus4.tx_data !== 8'h5A || bus4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_data: got txv=%b tx=%h busy=%b at A+6, required 1 5a 0", bus4.tx_valid, bus4.tx_data, bus4.busy);
    end
    en_cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus4.ram_en === 1'b1) en_cnt++;
    end
    bus4.rx_valid = 1'b0;
    n_checks++;
    if (en_cnt != 0 || bus4.err_seq !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_dropped: got %0d accesses err_seq=%b, required 0 1", en_cnt, bus4.err_seq);
    end
    @(posedge clk); #1;
    bus4.clr_err = 1'b1;
    @(posedge clk); #1;
    bus4.clr_err = 1'b0;
    n_checks++;
    if (bus4.err_ovf !== 1'b0 || bus4.err_seq !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_clr: got ovf=%b seq=%b, required 0 0", bus4.err_ovf, bus4.err_seq);
    end
    // clear coinciding with an overflow set: clear wins
    @(posedge clk); #1;
    bus4.rx_data  = 10'h300;
    bus4.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus4.rx_valid = 1'b0;
    @(posedge clk); #1;
    bus4.rx_data  = 10'h199;
    bus4.rx_valid = 1'b1;
    bus4.clr_err  = 1'b1;
    @(posedge clk); #1;
    bus4.clr_err  = 1'b0;
    n_checks++;
    if (bus4.err_ovf !== 1'b0 || bus4.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_clr_prio: got ovf=%b busy=%b, required 0 1", bus4.err_ovf, bus4.busy);
    end
    repeat (6) @(posedge clk);
    #1;
    bus4.rx_valid = 1'b0;
  endtask

  task automatic test_seq_after_reset();
    int bad = 0;
    bus1.rx_data  = 10'h155;
    bus1.rx_valid = 1'b1;
    apply_reset();
    repeat (4) begin
      @(posedge clk); #1;
      if (bus1.busy !== 1'b0 || bus1.ram_en !== 1'b0) bad++;
    end
    bus1.rx_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL t5_held: got %0d busy cycles after release, required 0", bad);
    end
    do_read1();
    n_checks++;
    if (bus1.err_seq !== 1'b1 || bus1.err_ovf !== 1'b0 || bus1.tx_data !== 8'h22) begin
      n_fail++;
      $display("FAIL t5_seq: got seq=%b ovf=%b tx=%h, required 1 0 22", bus1.err_seq, bus1.err_ovf, bus1.tx_data);
    end
  endtask

  task automatic test_reset_in_read();
    set_rd1(8'hFF);
    acc_q.push_back('{we: 1'b0, addr: 8'hFF, wdata: 8'h00});
    send1(10'h300);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus1.ram_en !== 1'b0 || bus1.busy !== 1'b0 || bus1.tx_valid !== 1'b0 || bus1.err_seq !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_abort: got en=%b busy=%b txv=%b seq=%b, required 0 0 0 0",
               bus1.ram_en, bus1.busy, bus1.tx_valid, bus1.err_seq);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wr_m = 8'h00;
    rd_m = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus1.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_late_tx: got tx_valid=%b, required 0", bus1.tx_valid);
    end
    set_rd1(8'hFF);
    do_read1();
    n_checks++;
    if (bus1.tx_valid !== 1'b1 || bus1.tx_data !== 8'h11 || bus1.err_seq !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_next: got txv=%b tx=%h seq=%b, required 1 11 0", bus1.tx_valid, bus1.tx_data, bus1.err_seq);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus1.rx_data  = '0;
    bus1.rx_valid = 1'b0;
    bus1.clr_err  = 1'b0;
    bus4.rx_data  = '0;
    bus4.rx_valid = 1'b0;
    bus4.clr_err  = 1'b0;
    wr_m = 8'h00;
    rd_m = 8'h00;
    fork
      monitor1();
    join_none

    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_overflow();
    test_seq_after_reset();
    test_reset_in_read();

    repeat (2) @(posedge clk);
    n_checks++;
    if (acc_q.size() != 0 || tx_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d accesses and %0d tx pending, required 0 0", acc_q.size(), tx_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
